// File: rtl/nand_logic_unit.sv
// nand_logic_unit
//   Registered, WIDTH-lane two-input logic unit. Every function is a fixed
//   network of nand_gate cells; the op select picks one network output per
//   lane. A one-deep valid/ready register holds the result with the op and
//   operands that produced it. A built-in sweep mode replays the full
//   two-input truth table of all eight ops (32 results) through the same
//   output register, stalling under backpressure.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  external operand handshake (in_ready is combinational)
//   op, a, b        operation select and operands
//   sweep_start     one-cycle request to start the truth-table sweep
//   sweep_busy      sweep in progress
//   sweep_done      one-cycle pulse after the last sweep result is loaded
//   out_valid/ready result handshake
//   y, out_op, out_a, out_b  result and the op/operands that produced it
//
// Op encoding: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a

module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module nand_logic_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       out_op,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t     state;
  logic [4:0] cnt;

  logic             load_ok;
  logic             src_valid;
  logic             load;
  logic [2:0]       src_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] f_nand, f_and, f_or, f_nor;
  logic [WIDTH-1:0] f_xor, f_xnor, f_not, f_buf;

  assign load_ok  = ~out_valid | out_ready;
  assign in_ready = (state == IDLE) & ~sweep_start & load_ok;

  // Source select: in SWEEP the counter drives op/a/b and is always valid;
  // in IDLE a simultaneous sweep_start blocks external operands.
  always_comb begin
    src_valid = 1'b0;
    src_op    = op;
    src_a     = a;
    src_b     = b;
    if (state == SWEEP) begin
      src_valid = 1'b1;
      src_op    = cnt[4:2];
      src_a     = {WIDTH{cnt[1]}};
      src_b     = {WIDTH{cnt[0]}};
    end else if (state == IDLE) begin
      src_valid = in_valid & ~sweep_start;
    end
  end

  assign load = src_valid & load_ok;

  // Per-lane NAND networks
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic na, nb, t1, t2;

    nand_gate u_nab  (.a(src_a[i]),  .b(src_b[i]),  .y(f_nand[i]));
    nand_gate u_and  (.a(f_nand[i]), .b(f_nand[i]), .y(f_and[i]));
    nand_gate u_na   (.a(src_a[i]),  .b(src_a[i]),  .y(na));
    nand_gate u_nb   (.a(src_b[i]),  .b(src_b[i]),  .y(nb));
    nand_gate u_or   (.a(na),        .b(nb),        .y(f_or[i]));
    nand_gate u_nor  (.a(f_or[i]),   .b(f_or[i]),   .y(f_nor[i]));
    // Classic four-NAND XOR sharing the a-nand-b term
    nand_gate u_t1   (.a(src_a[i]),  .b(f_nand[i]), .y(t1));
    nand_gate u_t2   (.a(src_b[i]),  .b(f_nand[i]), .y(t2));
    nand_gate u_xor  (.a(t1),        .b(t2),        .y(f_xor[i]));
    nand_gate u_xnor (.a(f_xor[i]),  .b(f_xor[i]),  .y(f_xnor[i]));
    nand_gate u_buf  (.a(na),        .b(na),        .y(f_buf[i]));
    assign f_not[i] = na;
  end

  always_comb begin
    result = '0;
    unique case (src_op)
      3'd0: result = f_nand;
      3'd1: result = f_and;
      3'd2: result = f_or;
      3'd3: result = f_nor;
      3'd4: result = f_xor;
      3'd5: result = f_xnor;
      3'd6: result = f_not;
      3'd7: result = f_buf;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      out_valid  <= 1'b0;
      y          <= '0;
      out_op     <= '0;
      out_a      <= '0;
      out_b      <= '0;
    end else begin
      // Output register
      if (load) begin
        out_valid <= 1'b1;
        y         <= result;
        out_op    <= src_op;
        out_a     <= src_a;
        out_b     <= src_b;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Sequencer
      unique case (state)
        IDLE: begin
          sweep_done <= 1'b0;
          if (sweep_start) begin
            state      <= SWEEP;
            cnt        <= '0;
            sweep_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (load) begin
            if (cnt == 5'd31) begin
              state      <= DONE;
              sweep_busy <= 1'b0;
              sweep_done <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          sweep_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          sweep_busy <= 1'b0;
          sweep_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
